// File: rtl/ccg34_pkg.sv
// Shared constants, types and helper functions for the CCGRCG34 response checker.
package ccg34_pkg;

  localparam int RESP_W = 19;

  localparam logic [RESP_W-1:0] MISR_SEED = 19'h7FFFF;
  localparam int MISR_TAP0 = 0;
  localparam int MISR_TAP1 = 1;
  localparam int MISR_TAP2 = 5;
  localparam int MISR_TAP3 = 18;

  // Golden response per stimulus pair, indexed by {x1, x0}.
  localparam logic [RESP_W-1:0] GOLD [4] = '{19'h1EFA5, 19'h37E85, 19'h34E85, 19'h74FA5};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] pair;
  } dec_t;

  function automatic logic [RESP_W-1:0] golden(input logic [1:0] stim);
    return GOLD[stim];
  endfunction

  // The four table entries are distinct, so at most one can hit.
  function automatic dec_t decode(input logic [RESP_W-1:0] word);
    dec_t r;
    r = '0;
    for (int p = 0; p < 4; p++) begin
      if (word == GOLD[p]) begin
        r.hit  = 1'b1;
        r.pair = p[1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ccg34_response_checker_misr.sv
// 19-bit MISR compressing accepted response words; seeded at session start.
module ccg34_misr
  import ccg34_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load_i,
  input  logic              en_i,
  input  logic [RESP_W-1:0] data_i,
  output logic [RESP_W-1:0] sig_o
);

  logic [RESP_W-1:0] sig_q;
  logic              fb;

  assign fb    = sig_q[MISR_TAP3] ^ sig_q[MISR_TAP2] ^ sig_q[MISR_TAP1] ^ sig_q[MISR_TAP0];
  assign sig_o = sig_q;

  always_ff @(posedge clk) begin
    if (rst || seed_load_i) begin
      sig_q <= MISR_SEED;
    end else if (en_i) begin
      sig_q <= {sig_q[RESP_W-2:0], fb} ^ data_i;
    end
  end

endmodule

// File: rtl/ccg34_response_checker.sv
// Session-based checker: compares response words to the golden table, decodes,
// counts saturating mismatches, captures the first failure and feeds a MISR.
module ccg34_response_checker
  import ccg34_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = $clog2(NUM_VEC) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_stim,
  input  logic [RESP_W-1:0] in_word,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [1:0]        decoded,
  output logic              dec_valid,
  output logic [RESP_W-1:0] signature,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [RESP_W-1:0] first_fail_word,
  output logic              fail_seen
);

  state_t            state_q;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  ff_idx_q;
  logic [RESP_W-1:0] ff_word_q;
  logic              fail_seen_q;
  logic              pass_q;
  logic [1:0]        dec_q;
  logic              dec_vld_q;

  logic              hs;
  logic              mismatch;
  logic              last_vec;
  dec_t              dec;

  assign hs       = in_valid && (state_q == ST_RUN);
  assign mismatch = (in_word != golden(in_stim));
  assign last_vec = (idx_q == IDX_W'(NUM_VEC - 1));
  assign dec      = decode(in_word);

  always_comb begin
    err_d = err_q;
    if (hs && mismatch && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      err_q       <= '0;
      idx_q       <= '0;
      ff_idx_q    <= '0;
      ff_word_q   <= '0;
      fail_seen_q <= 1'b0;
      pass_q      <= 1'b0;
      dec_q       <= '0;
      dec_vld_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            err_q       <= '0;
            idx_q       <= '0;
            ff_idx_q    <= '0;
            ff_word_q   <= '0;
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (hs) begin
            err_q     <= err_d;
            idx_q     <= idx_q + IDX_W'(1);
            dec_q     <= dec.hit ? dec.pair : 2'b00;
            dec_vld_q <= dec.hit;
            if (mismatch && !fail_seen_q) begin
              fail_seen_q <= 1'b1;
              ff_idx_q    <= idx_q;
              ff_word_q   <= in_word;
            end
            // pass must include the final vector, so it uses the next count.
            if (last_vec) begin
              state_q <= ST_DONE;
              pass_q  <= (err_d == '0);
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ccg34_misr u_misr (
    .clk         (clk),
    .rst         (rst),
    .seed_load_i ((state_q == ST_IDLE) && start),
    .en_i        (hs),
    .data_i      (in_word),
    .sig_o       (signature)
  );

  assign in_ready        = (state_q == ST_RUN);
  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign decoded         = dec_q;
  assign dec_valid       = dec_vld_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_word = ff_word_q;
  assign fail_seen       = fail_seen_q;

endmodule

// File: tb/tb_ccg34_response_checker.sv
// Scoreboard bench for ccg34_response_checker; a second instance covers counter saturation.
module tb_ccg34_response_checker;

  localparam int NV  = 4;
  localparam int CW  = 16;
  localparam int IW  = $clog2(NV) + 1;
  localparam int NV2 = 5;
  localparam int CW2 = 2;
  localparam int IW2 = $clog2(NV2) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [1:0]  in_stim = '0;
  logic [18:0] in_word = '0;
  logic        in_ready, busy, done, pass, dec_valid, fail_seen;
  logic [CW-1:0] err_count;
  logic [1:0]  decoded;
  logic [18:0] signature, first_fail_word;
  logic [IW-1:0] first_fail_idx;

  logic        s_start = 1'b0, s_valid = 1'b0;
  logic [1:0]  s_stim = '0;
  logic [18:0] s_word = '0;
  logic        s_ready, s_busy, s_done, s_pass, s_dv, s_fs;
  logic [CW2-1:0] s_err;
  logic [1:0]  s_dec;
  logic [18:0] s_sig, s_ffw;
  logic [IW2-1:0] s_ffi;

  ccg34_response_checker #(.NUM_VEC(NV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_stim(in_stim), .in_word(in_word), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .decoded(decoded), .dec_valid(dec_valid), .signature(signature),
    .first_fail_idx(first_fail_idx), .first_fail_word(first_fail_word), .fail_seen(fail_seen)
  );

  ccg34_response_checker #(.NUM_VEC(NV2), .CNT_W(CW2)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_stim(s_stim), .in_word(s_word), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .decoded(s_dec), .dec_valid(s_dv), .signature(s_sig),
    .first_fail_idx(s_ffi), .first_fail_word(s_ffw), .fail_seen(s_fs)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Golden word built from the boolean definitions of each output bit.
  function automatic logic [18:0] m_gold(input logic [1:0] s);
    logic [18:0] w;
    logic x0, x1;
    x0 = s[0];
    x1 = s[1];
    w = 19'h14E85;
    w[5]  = ~(x0 ^ x1);
    w[8]  = ~(x0 ^ x1);
    w[12] = x0 & ~x1;
    w[13] = ~x1;
    w[15] = ~(x0 | x1);
    w[17] = x0 | x1;
    w[18] = x0 & x1;
    return w;
  endfunction

  function automatic logic [18:0] misr_step(input logic [18:0] s, input logic [18:0] w);
    logic fb;
    fb = s[18] ^ s[5] ^ s[1] ^ s[0];
    return {s[17:0], fb} ^ w;
  endfunction

  typedef struct packed {
    logic [1:0]  dec;
    logic        dv;
    logic [15:0] err;
    logic [18:0] sig;
    logic        fs;
    logic [2:0]  ffi;
    logic [18:0] ffw;
  } exp_t;

  exp_t exp_q[$];

  int          m_st = 0;
  int          m_idx = 0;
  logic [15:0] m_err = '0;
  logic        m_fs = 1'b0, m_pass = 1'b0;
  logic [2:0]  m_ffi = '0;
  logic [18:0] m_ffw = '0, m_sig = 19'h7FFFF;

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_err = '0; m_fs = 1'b0; m_pass = 1'b0;
    m_ffi = '0; m_ffw = '0; m_sig = 19'h7FFFF;
  endtask

  // Scoreboard consumer: one entry per handshake seen on the previous edge.
  logic hs_q = 1'b0;
  int   hs_cnt = 0;
  always @(posedge clk) hs_q <= in_valid && in_ready && !rst;

  always @(negedge clk) begin
    exp_t e;
    if (hs_q) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("decoded",         32'(decoded),         32'(e.dec));
        chk("dec_valid",       32'(dec_valid),       32'(e.dv));
        chk("err_count",       32'(err_count),       32'(e.err));
        chk("signature",       32'(signature),       32'(e.sig));
        chk("fail_seen",       32'(fail_seen),       32'(e.fs));
        chk("first_fail_idx",  32'(first_fail_idx),  32'(e.ffi));
        chk("first_fail_word", 32'(first_fail_word), 32'(e.ffw));
      end
    end
  end

  // One clock of stimulus: check control outputs against the model, drive, advance the model.
  task automatic cyc(input logic st, input logic v, input logic [1:0] s, input logic [18:0] w);
    exp_t e;
    logic mism;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(m_st == 1));
    chk("busy",     32'(busy),     32'(m_st == 1));
    chk("done",     32'(done),     32'(m_st == 2));
    chk("pass",     32'(pass),     32'(m_pass));
    start = st; in_valid = v; in_stim = s; in_word = w;
    case (m_st)
      0: if (st) begin
        model_reset();
        m_st = 1;
      end
      1: if (v) begin
        mism = (w != m_gold(s));
        if (mism && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        if (mism && !m_fs) begin
          m_fs = 1'b1; m_ffi = m_idx[2:0]; m_ffw = w;
        end
        m_sig = misr_step(m_sig, w);
        e.dec = 2'b00; e.dv = 1'b0;
        for (int p = 0; p < 4; p++) begin
          if (w == m_gold(p[1:0])) begin
            e.dec = p[1:0]; e.dv = 1'b1;
          end
        end
        e.err = m_err; e.sig = m_sig; e.fs = m_fs; e.ffi = m_ffi; e.ffw = m_ffw;
        exp_q.push_back(e);
        m_idx++;
        if (m_idx == NV) begin
          m_st = 2;
          m_pass = (m_err == 16'd0);
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic do_reset(input logic with_start);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    start = with_start;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    model_reset();
    chk("rst_in_ready",  32'(in_ready),        32'd0);
    chk("rst_busy",      32'(busy),            32'd0);
    chk("rst_done",      32'(done),            32'd0);
    chk("rst_pass",      32'(pass),            32'd0);
    chk("rst_err",       32'(err_count),       32'd0);
    chk("rst_decoded",   32'(decoded),         32'd0);
    chk("rst_dec_valid", 32'(dec_valid),       32'd0);
    chk("rst_signature", 32'(signature),       32'h7FFFF);
    chk("rst_ff_idx",    32'(first_fail_idx),  32'd0);
    chk("rst_ff_word",   32'(first_fail_word), 32'd0);
    chk("rst_fail_seen", 32'(fail_seen),       32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 19'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    do_reset(1'b0);

    // Clean session, back-to-back.
    cyc(1'b1, 1'b0, 2'b00, 19'h0);
    for (int i = 0; i < NV; i++) cyc(1'b0, 1'b1, 2'(i), m_gold(2'(i)));
    idle(3);
    chk("clean_pass", 32'(pass),      32'd1);
    chk("clean_err",  32'(err_count), 32'd0);

    // Bit flip on vector 1, decodable mismatch on vector 2, start ignored mid-run.
    cyc(1'b1, 1'b0, 2'b00, 19'h0);
    cyc(1'b0, 1'b1, 2'b00, m_gold(2'b00));
    cyc(1'b0, 1'b1, 2'b01, 19'h37E84);
    cyc(1'b1, 1'b0, 2'b00, 19'h0);
    cyc(1'b0, 1'b1, 2'b00, 19'h74FA5);
    chk("decodable_dec", 32'(decoded),   32'd0);
    cyc(1'b0, 1'b1, 2'b11, m_gold(2'b11));
    idle(3);
    chk("flip_ff_idx",  32'(first_fail_idx),  32'd1);
    chk("flip_ff_word", 32'(first_fail_word), 32'h37E84);
    chk("flip_err",     32'(err_count),       32'd2);
    chk("flip_pass",    32'(pass),            32'd0);

    // in_valid held high past the session length.
    base = hs_cnt;
    cyc(1'b1, 1'b0, 2'b00, 19'h0);
    for (int i = 0; i < NV + 3; i++) cyc(1'b0, 1'b1, 2'(i % 4), m_gold(2'(i % 4)));
    idle(3);
    chk("flow_handshakes", 32'(hs_cnt - base), 32'(NV));

    // Reset after two vectors, then a full clean session.
    cyc(1'b1, 1'b0, 2'b00, 19'h0);
    cyc(1'b0, 1'b1, 2'b00, 19'h00001);
    cyc(1'b0, 1'b1, 2'b01, m_gold(2'b01));
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 2'b00, 19'h0);
    for (int i = 0; i < NV; i++) cyc(1'b0, 1'b1, 2'(3 - i), m_gold(2'(3 - i)));
    idle(3);
    chk("post_rst_pass", 32'(pass), 32'd1);

    // rst and start together on the same edge.
    do_reset(1'b1);
    idle(2);

    // Saturation on the narrow-counter instance.
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("sat_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < NV2; i++) begin
      s_valid = 1'b1;
      s_stim  = 2'(i % 4);
      s_word  = m_gold(2'(i % 4)) ^ 19'h00100;
      @(negedge clk);
      chk("sat_err", 32'(s_err), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    s_valid = 1'b0;
    chk("sat_done", 32'(s_done), 32'd1);
    chk("sat_pass", 32'(s_pass), 32'd0);
    chk("sat_ff_idx", 32'(s_ffi), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccg34_response_checker.md
# ccg34_response_checker

Sequential response checker on the output side of the CCGRCG34 two-input, nineteen-output benchmark. It accepts captured 19-bit response words with the stimulus pair that produced them, and compares each word against the golden function table. It also decodes each word back to its input pair, counts mismatches, records the first failure and compresses all responses into a MISR signature. It sits between the benchmark (or its gate-level netlist) and the test-session controller in the evaluation harness.

## Interface
- NUM_VEC, 16, vectors per session (≥1)
- CNT_W, 16, error-counter width
- IDX_W, $clog2(NUM_VEC)+1, vector-index width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin session; honoured only in IDLE
- in_valid  in  1  response word present
- in_ready  out  1  checker accepts this cycle
- in_stim  in  2  applied pair, [0]=x0, [1]=x1
- in_word  in  19  response, bit k = f(k+1)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at session end
- pass  out  1  err_count==0 at last done; held until next start
- err_count  out  CNT_W  mismatches, saturating
- decoded  out  2  pair recovered from last accepted word
- dec_valid  out  1  last word matched a table entry exactly
- signature  out  19  MISR state
- first_fail_idx  out  IDX_W  vector index of first mismatch
- first_fail_word  out  19  word of first mismatch
- fail_seen  out  1  first_fail_* valid

## Operation
- Golden table (constant ones at bits 0,2,7,9,10,11,14,16): stim 00→0x1EFA5, 01→0x37E85, 10→0x34E85, 11→0x74FA5. Variable bits: 5,8=XNOR; 12=x0&~x1; 13=~x1; 15=NOR; 17=OR; 18=AND.
- FSM: IDLE→RUN on start (clears err_count, fail_seen, first_fail_*, vector index, pass; seeds signature to 0x7FFFF). RUN→DONE on the edge accepting vector NUM_VEC-1. DONE→IDLE unconditionally after 1 cycle.
- in_ready = (state==RUN). A handshake occurs when in_valid&in_ready.
- Per handshake: mismatch = (in_word != golden(in_stim)). err_count increments when it is below its maximum. On the first mismatch of the session, capture the index and word and set fail_seen.
- Decode is independent of in_stim. On an exact match with entry p: decoded=p, dec_valid=1. Otherwise decoded=0, dec_valid=0.
- MISR: fb = s[18]^s[5]^s[1]^s[0]; s_next = {s[17:0],fb} ^ in_word. Updated only on a handshake.
- start in RUN or DONE is ignored. in_valid outside RUN is ignored. No state changes.
- pass is updated in DONE only: pass = (err_count==0), including the final vector.

## Timing
- Reset values: state IDLE, in_ready 0, busy 0, done 0, pass 0, err_count 0, decoded 0, dec_valid 0, signature 0x7FFFF, first_fail_* 0, fail_seen 0.
- Latency 1: every result of a handshake at edge k is visible after edge k.
- The first in_ready comes 1 cycle after start is sampled. Back-to-back handshakes are allowed at 1 vector per cycle.
- done and pass are valid in the cycle after the final handshake. busy falls in the same cycle.
- rst mid-RUN forces all reset values at that edge. A partial session leaves no residue.
- A rst and start asserted on the same edge resolve to reset.

## Structure
- ccg34_pkg holds:
  - GOLD[4] constants
  - RESP_W=19
  - MISR seed and tap positions
  - function golden(stim)
  - function decode(word) returning {hit, pair}
- One sub-module, ccg34_misr: clk, rst, seed_load, en, data[18:0] → sig[18:0].
- The FSM, counters and capture logic live in the top.

## Test plan
- Reset: apply rst for 2 cycles → in_ready 0, signature 0x7FFFF, all other outputs 0.
- Clean run, NUM_VEC=4: stims 00,01,10,11 sent back-to-back with golden words → decoded 00,01,10,11 each with dec_valid=1. done pulses one cycle after the 4th handshake, pass=1, err_count=0, signature equal to the bench MISR model.
- Bit flip: stim 01 with word 0x37E84 as vector 1 → err_count=1, dec_valid=0, first_fail_idx=1, first_fail_word=0x37E84, fail_seen=1, pass=0 at done.
- Decodable mismatch: stim 00 with word 0x74FA5 → error counted, decoded=11, dec_valid=1. A later mismatch does not overwrite first_fail_*.
- Flow control: in_valid held high beyond NUM_VEC vectors → exactly NUM_VEC handshakes, then in_ready 0. start pulsed during RUN → no clear, session continues.
- Saturation and reset: CNT_W=2 with 5 bad vectors → err_count stays at 3. rst asserted after vector 2 of a session → all reset values, and the next start runs a full clean session.
